fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: request, memory and result signals of the instruction fetch
// unit. The fetch unit connects through the master modport; the requesting
// core plus byte-wide memory sit on the slave side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_BYTES = 2
);
    logic                    en;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    flush;
    logic [7:0]              data_in;
    logic                    mem_ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    mem_req;
    logic [8*INST_BYTES-1:0] inst_out;
    logic                    ready;
    logic                    hit;

    modport master (
        input  en, pc, flush, data_in, mem_ready,
        output addr, mem_req, inst_out, ready, hit
    );

    modport slave (
        output en, pc, flush, data_in, mem_ready,
        input  addr, mem_req, inst_out, ready, hit
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetches INST_BYTES-byte instructions from a byte-wide memory,
// one byte per request, most significant byte at pc. An optional
// direct-mapped instruction cache is included when the macro
// FETCH_ICACHE_EN is defined; without it every lookup misses and hit stays 0.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INST_BYTES  = 2,
    parameter int CACHE_CELLS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int IDX_W = $clog2(CACHE_CELLS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int KW    = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int W     = 8 * INST_BYTES;
    localparam logic [KW-1:0] K_LAST = KW'(INST_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        MEM,
        DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [KW-1:0]         k_q;
    logic                  mem_req_q;
    logic [W-1:0]          inst_q;
    logic                  ready_q;
    logic                  hit_q;

    logic                  lookup_hit;
    logic [W-1:0]          lookup_word;
    logic                  last_beat;

    assign last_beat = (k_q == K_LAST);

`ifdef FETCH_ICACHE_EN
    logic [CACHE_CELLS-1:0] valid_q;
    logic [TAG_W-1:0]       tag_mem [CACHE_CELLS];
    logic [W-1:0]           data_mem [CACHE_CELLS];
    logic [TAG_W-1:0]       rd_tag_q;
    logic [W-1:0]           rd_word_q;
    logic [IDX_W-1:0]       pc_idx;
    logic [IDX_W-1:0]       cur_idx;
    logic [TAG_W-1:0]       cur_tag;
    logic                   fill_we;
    logic [W-1:0]           fill_word;

    assign pc_idx  = bus.pc[IDX_W-1:0];
    assign cur_idx = pc_q[IDX_W-1:0];
    assign cur_tag = pc_q[ADDR_WIDTH-1:IDX_W];

    // The fill happens on the final accepted byte of a fetch that is not
    // being aborted; reset in the same cycle suppresses it.
    assign fill_we = rst_n && (state_q == MEM) && bus.en && bus.mem_ready && last_beat;

    // Final byte lands in the least significant lane, so the stored word is
    // the assembled upper bytes plus the byte arriving now.
    always_comb begin
        fill_word      = inst_q;
        fill_word[7:0] = bus.data_in;
    end

    // Valid bits: cleared by reset or flush (flush beats a coincident fill).
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            valid_q <= '0;
        end else if (fill_we) begin
            valid_q[cur_idx] <= 1'b1;
        end
    end

    // Tag/data storage with registered read, read as the request is latched.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= fill_word;
        end
        if (state_q == IDLE && bus.en) begin
            rd_tag_q  <= tag_mem[pc_idx];
            rd_word_q <= data_mem[pc_idx];
        end
    end

    // A flush seen during lookup forces a miss.
    assign lookup_hit  = valid_q[cur_idx] && (rd_tag_q == cur_tag) && !bus.flush;
    assign lookup_word = rd_word_q;
`else
    assign lookup_hit  = 1'b0;
    assign lookup_word = '0;
`endif

    // Fetch sequencer with registered outputs; en low mid-fetch aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            k_q       <= '0;
            mem_req_q <= 1'b0;
            inst_q    <= '0;
            ready_q   <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        pc_q    <= bus.pc;
                        k_q     <= '0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end else if (lookup_hit) begin
                        inst_q  <= lookup_word;
                        hit_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        addr_q    <= pc_q;
                        mem_req_q <= 1'b1;
                        state_q   <= MEM;
                    end
                end
                ISSUE: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end else begin
                        addr_q    <= pc_q + ADDR_WIDTH'(k_q);
                        mem_req_q <= 1'b1;
                        state_q   <= MEM;
                    end
                end
                MEM: begin
                    if (!bus.en) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        for (int b = 0; b < INST_BYTES; b++) begin
                            if (k_q == KW'(b)) begin
                                inst_q[8*(INST_BYTES-1-b) +: 8] <= bus.data_in;
                            end
                        end
                        if (last_beat) begin
                            hit_q   <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.en) begin
                        ready_q <= 1'b0;
                        hit_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addr     = addr_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.inst_out = inst_q;
    assign bus.ready    = ready_q;
    assign bus.hit      = hit_q;
endmodule
